// File: rtl/sseg_scan_decoder.sv
// ============================================================================
// Module   : sseg_scan_decoder
// Brief    : Recovers hex nibbles from a multiplexed active-low 7-segment bus
//            and publishes a frame once it has repeated STABLE_FRAMES times.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sseg_scan_decoder #(
    parameter int N_DIGITS      = 4,
    parameter int SETTLE_CYCLES = 3,
    parameter int STABLE_FRAMES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [0:6]              sseg,
    input  logic [N_DIGITS-1:0]     an,
    output logic [4*N_DIGITS-1:0]   digits,
    output logic [N_DIGITS-1:0]     digit_err,
    output logic                    valid,
    output logic                    frame_done,
    output logic                    an_err
);

    localparam int       c_IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [7:0] c_SETTLE = 8'(SETTLE_CYCLES);
    localparam logic [3:0] c_STABLE = 4'(STABLE_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_IDX_W-1:0]     r_curK;
    logic [N_DIGITS-1:0]    r_curAn;
    logic [0:6]             r_curSeg;
    logic [7:0]             r_cnt;
    logic [4*N_DIGITS-1:0]  r_shadowNib;
    logic [N_DIGITS-1:0]    r_shadowErr;
    logic [4*N_DIGITS-1:0]  r_prevNib;
    logic [N_DIGITS-1:0]    r_prevErr;
    logic                   r_havePrev;
    logic [N_DIGITS-1:0]    r_captured;
    logic [3:0]             r_matchCnt;

    logic                   w_anyLow;
    logic                   w_multiLow;
    logic [c_IDX_W-1:0]     w_selIdx;
    logic                   w_select;
    logic                   w_illegal;
    logic                   w_changed;
    logic                   w_doEval;
    state_t                 w_evalState;
    logic [7:0]             w_cntInc;
    logic [3:0]             w_decNib;
    logic                   w_decErr;
    logic [4*N_DIGITS-1:0]  w_nibNext;
    logic [N_DIGITS-1:0]    w_errNext;
    logic [N_DIGITS-1:0]    w_capMask;
    logic                   w_frameComplete;
    logic                   w_sameFrame;
    logic [3:0]             w_matchNext;

    always_comb begin
        w_anyLow   = 1'b0;
        w_multiLow = 1'b0;
        w_selIdx   = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!an[i]) begin
                if (w_anyLow) w_multiLow = 1'b1;
                w_anyLow = 1'b1;
                w_selIdx = i[c_IDX_W-1:0];
            end
        end
    end

    assign w_select  = w_anyLow && !w_multiLow;
    assign w_illegal = w_multiLow;
    assign w_changed = (an != r_curAn) || (sseg != r_curSeg);
    assign w_cntInc  = r_cnt + 8'd1;

    // A change while settling or holding is treated exactly like a fresh IDLE look.
    assign w_doEval    = (r_state == S_IDLE) ||
                         (((r_state == S_SETTLE) || (r_state == S_HOLD)) && w_changed);
    assign w_evalState = !w_select ? S_IDLE :
                         (c_SETTLE <= 8'd1) ? S_CAPTURE : S_SETTLE;

    always_comb begin
        w_decNib = 4'h0;
        w_decErr = 1'b0;
        case (r_curSeg)
            7'b0000001: w_decNib = 4'h0;
            7'b1001111: w_decNib = 4'h1;
            7'b0010010: w_decNib = 4'h2;
            7'b0000110: w_decNib = 4'h3;
            7'b1001100: w_decNib = 4'h4;
            7'b0100100: w_decNib = 4'h5;
            7'b0100000: w_decNib = 4'h6;
            7'b0001111: w_decNib = 4'h7;
            7'b0000000: w_decNib = 4'h8;
            7'b0000100: w_decNib = 4'h9;
            7'b0001000: w_decNib = 4'hA;
            7'b1100000: w_decNib = 4'hB;
            7'b0110001: w_decNib = 4'hC;
            7'b1000010: w_decNib = 4'hD;
            7'b0110000: w_decNib = 4'hE;
            7'b0111000: w_decNib = 4'hF;
            default:    w_decErr = 1'b1;
        endcase
    end

    // Shadow frame as it will look after this capture, used for the completion compare.
    always_comb begin
        w_nibNext = r_shadowNib;
        w_errNext = r_shadowErr;
        w_capMask = r_captured;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_curK == i[c_IDX_W-1:0]) begin
                w_nibNext[4*i +: 4] = w_decNib;
                w_errNext[i]        = w_decErr;
                w_capMask[i]        = 1'b1;
            end
        end
    end

    assign w_frameComplete = (r_state == S_CAPTURE) && (&w_capMask);
    assign w_sameFrame     = r_havePrev && (w_nibNext == r_prevNib) && (w_errNext == r_prevErr);
    assign w_matchNext     = !w_sameFrame ? 4'd1 :
                             (r_matchCnt >= c_STABLE) ? c_STABLE : (r_matchCnt + 4'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_curK      <= '0;
            r_curAn     <= '1;
            r_curSeg    <= '1;
            r_cnt       <= '0;
            r_shadowNib <= '0;
            r_shadowErr <= '0;
            r_prevNib   <= '0;
            r_prevErr   <= '0;
            r_havePrev  <= 1'b0;
            r_captured  <= '0;
            r_matchCnt  <= '0;
            digits      <= '0;
            digit_err   <= '0;
            valid       <= 1'b0;
            frame_done  <= 1'b0;
            an_err      <= 1'b0;
        end else begin
            an_err     <= 1'b0;
            frame_done <= 1'b0;
            if (w_doEval) begin
                r_state <= w_evalState;
                an_err  <= w_illegal;
                if (w_select) begin
                    r_curK   <= w_selIdx;
                    r_curAn  <= an;
                    r_curSeg <= sseg;
                    r_cnt    <= 8'd1;
                end
            end else begin
                case (r_state)
                    S_SETTLE: begin
                        r_cnt <= w_cntInc;
                        if (w_cntInc >= c_SETTLE) r_state <= S_CAPTURE;
                    end
                    S_CAPTURE: begin
                        r_state     <= S_HOLD;
                        r_shadowNib <= w_nibNext;
                        r_shadowErr <= w_errNext;
                        if (w_frameComplete) begin
                            r_captured <= '0;
                            frame_done <= 1'b1;
                            r_prevNib  <= w_nibNext;
                            r_prevErr  <= w_errNext;
                            r_havePrev <= 1'b1;
                            r_matchCnt <= w_matchNext;
                            if (w_matchNext == c_STABLE) begin
                                digits    <= w_nibNext;
                                digit_err <= w_errNext;
                                valid     <= 1'b1;
                            end
                        end else begin
                            r_captured <= w_capMask;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_decoder.sv
// ============================================================================
// Module   : tb_sseg_scan_decoder
// Brief    : Table-driven frame scans plus directed multi-cycle corner cases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sseg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [0:6]  sseg = 7'b1111111;
    logic [3:0]  an = 4'b1111;
    logic [15:0] digits;
    logic [3:0]  digit_err;
    logic        valid;
    logic        frame_done;
    logic        an_err;

    always #5 clk = ~clk;

    sseg_scan_decoder #(
        .N_DIGITS      (4),
        .SETTLE_CYCLES (3),
        .STABLE_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sseg       (sseg),
        .an         (an),
        .digits     (digits),
        .digit_err  (digit_err),
        .valid      (valid),
        .frame_done (frame_done),
        .an_err     (an_err)
    );

    typedef struct {
        logic [19:0] codes;
        logic [15:0] expDigits;
        logic [3:0]  expErr;
        logic        expValid;
    } vec_t;

    vec_t vecs[15];
    int   nVec = 0;
    int   nFail = 0;
    int   fdCount = 0;
    int   aeCount = 0;
    logic [15:0] lastDigits = '0;
    logic [3:0]  lastErr = '0;
    logic        lastValid = 1'b0;

    localparam logic [4:0] c_BAD = 5'd16;

    always @(negedge clk) begin
        if (frame_done) begin
            fdCount    = fdCount + 1;
            lastDigits = digits;
            lastErr    = digit_err;
            lastValid  = valid;
        end
        if (an_err) aeCount = aeCount + 1;
    end

    function automatic logic [0:6] glyph(input logic [4:0] c);
        case (c)
            5'd0:  return 7'b0000001;
            5'd1:  return 7'b1001111;
            5'd2:  return 7'b0010010;
            5'd3:  return 7'b0000110;
            5'd4:  return 7'b1001100;
            5'd5:  return 7'b0100100;
            5'd6:  return 7'b0100000;
            5'd7:  return 7'b0001111;
            5'd8:  return 7'b0000000;
            5'd9:  return 7'b0000100;
            5'd10: return 7'b0001000;
            5'd11: return 7'b1100000;
            5'd12: return 7'b0110001;
            5'd13: return 7'b1000010;
            5'd14: return 7'b0110000;
            5'd15: return 7'b0111000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [19:0] mk(input logic [4:0] d0, input logic [4:0] d1,
                                       input logic [4:0] d2, input logic [4:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec = nVec + 1;
        if (act !== exp) begin
            nFail = nFail + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scans digits 0..nDig-1, each for 'dwell' cycles followed by a one-cycle gap.
    task automatic scanFrame(input logic [19:0] codes, input int dwell,
                             input int illegalAfter, input int nDig);
        logic [3:0] a;
        for (int k = 0; k < nDig; k++) begin
            a = 4'b1111;
            a[k] = 1'b0;
            an = a;
            sseg = glyph(codes[5*k +: 5]);
            repeat (dwell) tick();
            an = (k == illegalAfter) ? 4'b0011 : 4'b1111;
            sseg = 7'b1111111;
            tick();
        end
        an = 4'b1111;
        tick();
        tick();
    endtask

    initial begin
        int fd0;
        int ae0;
        logic [19:0] base;
        base = mk(5'd3, 5'd0, 5'd10, 5'd15);

        vecs[0]  = '{base,                              16'h0000, 4'b0000, 1'b0};
        vecs[1]  = '{base,                              16'hFA03, 4'b0000, 1'b1};
        vecs[2]  = '{mk(5'd3, 5'd0, 5'd7, 5'd15),       16'hFA03, 4'b0000, 1'b1};
        vecs[3]  = '{base,                              16'hFA03, 4'b0000, 1'b1};
        vecs[4]  = '{base,                              16'hFA03, 4'b0000, 1'b1};
        vecs[5]  = '{mk(5'd3, 5'd5, 5'd10, 5'd15),      16'hFA03, 4'b0000, 1'b1};
        vecs[6]  = '{mk(5'd3, 5'd5, 5'd10, 5'd15),      16'hFA53, 4'b0000, 1'b1};
        vecs[7]  = '{mk(5'd3, c_BAD, 5'd10, 5'd15),     16'hFA53, 4'b0000, 1'b1};
        vecs[8]  = '{mk(5'd3, c_BAD, 5'd10, 5'd15),     16'hFA03, 4'b0010, 1'b1};
        vecs[9]  = '{mk(5'd1, 5'd2, 5'd4, 5'd5),        16'hFA03, 4'b0010, 1'b1};
        vecs[10] = '{mk(5'd1, 5'd2, 5'd4, 5'd5),        16'h5421, 4'b0000, 1'b1};
        vecs[11] = '{mk(5'd6, 5'd7, 5'd8, 5'd9),        16'h5421, 4'b0000, 1'b1};
        vecs[12] = '{mk(5'd6, 5'd7, 5'd8, 5'd9),        16'h9876, 4'b0000, 1'b1};
        vecs[13] = '{mk(5'd11, 5'd12, 5'd13, 5'd14),    16'h9876, 4'b0000, 1'b1};
        vecs[14] = '{mk(5'd11, 5'd12, 5'd13, 5'd14),    16'hEDCB, 4'b0000, 1'b1};

        repeat (2) tick();
        chk("reset digits", 32'(digits), 32'h0);
        chk("reset outputs", {27'd0, digit_err, valid}, 32'h0);
        chk("reset pulses", {30'd0, frame_done, an_err}, 32'h0);
        rst = 1'b1;
        tick();

        for (int v = 0; v < 15; v++) begin
            fd0 = fdCount;
            scanFrame(vecs[v].codes, 4, -1, 4);
            chk($sformatf("vec%0d frame_done", v), 32'(fdCount - fd0), 32'd1);
            chk($sformatf("vec%0d digits", v), 32'(lastDigits), 32'(vecs[v].expDigits));
            chk($sformatf("vec%0d digit_err", v), 32'(lastErr), 32'(vecs[v].expErr));
            chk($sformatf("vec%0d valid", v), 32'(lastValid), 32'(vecs[v].expValid));
        end

        // Illegal anode pattern in the gap after digit 1.
        fd0 = fdCount;
        ae0 = aeCount;
        scanFrame(vecs[14].codes, 4, 1, 4);
        chk("illegal an_err count", 32'(aeCount - ae0), 32'd1);
        chk("illegal frame_done", 32'(fdCount - fd0), 32'd1);
        chk("illegal digits", 32'(lastDigits), 32'hEDCB);

        // Dwell one short of the settle time never captures.
        fd0 = fdCount;
        scanFrame(base, 2, -1, 4);
        scanFrame(base, 2, -1, 4);
        chk("short dwell frame_done", 32'(fdCount - fd0), 32'd0);
        chk("short dwell digits", 32'(digits), 32'hEDCB);

        // Long dwell gives exactly one capture per digit.
        fd0 = fdCount;
        scanFrame(base, 50, -1, 4);
        chk("long dwell frame_done", 32'(fdCount - fd0), 32'd1);
        chk("long dwell digits", 32'(lastDigits), 32'hEDCB);
        fd0 = fdCount;
        scanFrame(base, 50, -1, 4);
        chk("long dwell 2 frame_done", 32'(fdCount - fd0), 32'd1);
        chk("long dwell 2 digits", 32'(lastDigits), 32'hFA03);

        // Reset after three captured digits discards the partial frame.
        chk("pre-reset valid", 32'(valid), 32'd1);
        scanFrame(base, 4, -1, 3);
        rst = 1'b0;
        #2;
        chk("mid reset digits", 32'(digits), 32'h0);
        chk("mid reset outputs", {27'd0, digit_err, valid}, 32'h0);
        chk("mid reset pulses", {30'd0, frame_done, an_err}, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        fd0 = fdCount;
        scanFrame(mk(5'd0, 5'd0, 5'd0, 5'd0), 4, -1, 4);
        chk("post reset f1 frame_done", 32'(fdCount - fd0), 32'd1);
        chk("post reset f1 valid", 32'(lastValid), 32'd0);
        scanFrame(mk(5'd0, 5'd0, 5'd0, 5'd0), 4, -1, 4);
        chk("post reset f2 frame_done", 32'(fdCount - fd0), 32'd2);
        chk("post reset f2 valid", 32'(lastValid), 32'd1);
        chk("post reset f2 digits", 32'(lastDigits), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sseg_scan_decoder.md
Name: sseg_scan_decoder

Overview:
- Receive-side counterpart of the register-bank display path: watches the multiplexed 7-segment bus (`sseg`, `an`) and recovers the hex nibble shown on each digit.
- Rebuilds a full frame from successive anode scans. Publishes it only after it has repeated identically for a set number of scans.
- Used for board loopback self-check and as a scoreboard front end in benches.

Parameters:
- N_DIGITS, 4, number of multiplexed digits, equal to the width of `an`.
- SETTLE_CYCLES, 3, consecutive cycles `an` and `sseg` must hold unchanged before a digit is sampled (range 1..255).
- STABLE_FRAMES, 2, consecutive identical complete frames needed before `digits` updates (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- sseg  in  [0:6]  segment bus, active-low, `sseg[0]`=a ... `sseg[6]`=g.
- an  in  [N_DIGITS-1:0]  anode enables, active-low. `an[k]` low selects digit k.
- digits  out  [4*N_DIGITS-1:0]  published nibbles; digit k is at bits [4k+3:4k].
- digit_err  out  [N_DIGITS-1:0]  published flag: digit k pattern was not a legal hex glyph.
- valid  out  1  high once any frame has been published.
- frame_done  out  1  one-cycle pulse on each completed frame, whether or not it is published.
- an_err  out  1  one-cycle pulse when more than one `an` bit is low.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - all outputs 0;
  - shadow frame, previous frame, captured flags, settle counter and match counter cleared;
  - FSM goes to IDLE.
- Input classification, evaluated every cycle:
  - `an` all ones = blank;
  - exactly one bit low = select k;
  - two or more bits low = illegal.
- FSM:
  - IDLE:
    - select k → latch k, `sseg` into `cur_k`/`cur_seg`, cnt=1, go to SETTLE.
    - illegal → pulse `an_err`, stay in IDLE.
    - blank → stay in IDLE.
  - SETTLE:
    - `an` and `sseg` unchanged → cnt++. When cnt reaches SETTLE_CYCLES, go to CAPTURE.
    - any change → back to IDLE, no capture. The new value is re-evaluated as in IDLE on the same cycle.
    - illegal → pulse `an_err` and go to IDLE.
  - CAPTURE (one cycle):
    - decode `cur_seg`, write nibble and error bit into shadow slot `cur_k`, set `captured[cur_k]`;
    - go to HOLD.
  - HOLD:
    - stay while `an` and `sseg` are unchanged, so one long display period counts as a single capture;
    - any change → IDLE, same-cycle evaluation.
- Decode table, active-low, `sseg[0:6]`:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111;
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - Any other pattern gives nibble 0 with the error bit set.
- Recapture: capturing slot k again before the frame completes overwrites slot k (last value wins).
- Frame completion, registered the cycle after the CAPTURE that sets the last captured flag:
  - pulse `frame_done`; clear all captured flags;
  - compare shadow (nibbles plus error bits) with the previous frame:
    - equal → match_cnt++, saturating at STABLE_FRAMES;
    - different → match_cnt=1;
  - copy shadow into the previous frame.
  - When match_cnt reaches STABLE_FRAMES:
    - load `digits` and `digit_err` from shadow in the same cycle as `frame_done`;
    - set `valid`=1.
  - With STABLE_FRAMES=1, every frame publishes.
- Latency: last digit's CAPTURE → `frame_done`/`digits` update exactly 1 cycle later.
- `valid` stays high until reset. `an_err` does not clear `valid` or captured flags.
- Reset mid-frame discards partial captures. The first frame after reset counts as match_cnt=1.
- Simultaneous `an_err` and frame completion: both pulses assert.

Test Plan:
- Reset, then scan glyphs 3,0,A,F on digits 0..3 (4-cycle dwell, 1-cycle blank gap), 2 frames → on the 2nd `frame_done`: `digits`=16'hFA03, `digit_err`=0, `valid`=1. After the 1st frame: `valid`=0.
- Change digit 2 from A to 7 for a single frame, then back to A → `digits` stays 16'hFA03 throughout; `frame_done` still pulses every frame.
- Drive `sseg`=1111111 on digit 1 for 2 frames → `digit_err`=4'b0010, nibble 1 reads 0.
- Drive `an`=4'b0011 for 1 cycle mid-scan → `an_err` pulses once, no capture; the following legal scans complete normally.
- Dwell of SETTLE_CYCLES-1 cycles per digit → never captures, `frame_done` never pulses. Dwell of 50 cycles → exactly one capture per digit.
- Deassert `rst` low for 1 cycle after 3 digits are captured → all outputs 0. Then 2 full frames are needed before `valid`=1.
